// File: rtl/wb2axil_pkg.sv
// Shared types and constants for the Wishbone-to-AXI4-Lite bridge.
package wb2axil_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    // SLVERR and DECERR terminate with an error; OKAY and EXOKAY do not.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
    endfunction

endpackage

// File: rtl/wb2axil_bridge.sv
// Wishbone classic slave to AXI4-Lite master bridge, one transaction at a time.
// Define WB2AXIL_POSTED_WRITE_EN to ack writes before B and track B errors in a sticky flag.
module wb2axil_bridge
    import wb2axil_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [ADDR_W-1:0]   wb_adr_i,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic [DATA_W/8-1:0] wb_sel_i,
    input  logic                wb_we_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic                wb_posted_err_o,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [2:0]          m_axi_awprot,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [2:0]          m_axi_arprot,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);

    localparam int unsigned SEL_W = DATA_W / 8;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [SEL_W-1:0]    sel_q;
    logic                req_c;
    logic                aw_ok_c;
    logic                w_ok_c;
    logic                b_err_c;
    logic                r_err_c;

`ifdef WB2AXIL_POSTED_WRITE_EN
    logic b_pending;
    logic posted_err;
    assign req_c           = wb_cyc_i && wb_stb_i && !wb_ack_o && !wb_err_o && !b_pending;
    assign wb_posted_err_o = posted_err;
`else
    assign req_c           = wb_cyc_i && wb_stb_i && !wb_ack_o && !wb_err_o;
    assign wb_posted_err_o = 1'b0;
`endif

    // A channel is finished once its valid has been accepted (or is about to be).
    assign aw_ok_c = !m_axi_awvalid || m_axi_awready;
    assign w_ok_c  = !m_axi_wvalid  || m_axi_wready;
    assign b_err_c = resp_is_err(m_axi_bresp);
    assign r_err_c = resp_is_err(m_axi_rresp);

    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_awprot = AXI_PROT_DEFAULT;
    assign m_axi_arprot = AXI_PROT_DEFAULT;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = sel_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state         <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            sel_q         <= '0;
            wb_dat_o      <= '0;
            wb_ack_o      <= 1'b0;
            wb_err_o      <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
`ifdef WB2AXIL_POSTED_WRITE_EN
            b_pending     <= 1'b0;
            posted_err    <= 1'b0;
`endif
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (req_c) begin
                        addr_q  <= wb_adr_i & ~ADDR_W'(3);
                        wdata_q <= wb_dat_i;
                        sel_q   <= wb_sel_i;
                        if (wb_we_i) begin
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= WR_REQ;
                        end else begin
                            m_axi_arvalid <= 1'b1;
                            state         <= RD_REQ;
                        end
                    end
                end

                WR_REQ: begin
                    if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
                    if (aw_ok_c && w_ok_c) begin
                        m_axi_bready <= 1'b1;
`ifdef WB2AXIL_POSTED_WRITE_EN
                        b_pending <= 1'b1;
                        wb_ack_o  <= wb_cyc_i;
                        state     <= DONE;
`else
                        state <= WR_RESP;
`endif
                    end
                end

                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        wb_ack_o     <= wb_cyc_i && !b_err_c;
                        wb_err_o     <= wb_cyc_i && b_err_c;
                        state        <= DONE;
                    end
                end

                RD_REQ: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RD_RESP;
                    end
                end

                RD_RESP: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        wb_dat_o     <= m_axi_rdata;
                        wb_ack_o     <= wb_cyc_i && !r_err_c;
                        wb_err_o     <= wb_cyc_i && r_err_c;
                        state        <= DONE;
                    end
                end

                DONE: state <= IDLE;

                default: state <= IDLE;
            endcase

`ifdef WB2AXIL_POSTED_WRITE_EN
            // Background B consumption for the one outstanding posted write.
            if (m_axi_bready && m_axi_bvalid) begin
                m_axi_bready <= 1'b0;
                b_pending    <= 1'b0;
                if (b_err_c) posted_err <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_wb2axil_bridge.sv
// Directed self-checking bench for wb2axil_bridge; follows WB2AXIL_POSTED_WRITE_EN when defined.
module tb_wb2axil_bridge;

`ifdef WB2AXIL_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_w;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_stb;
    logic [31:0] wb_dat_r;
    logic        wb_ack;
    logic        wb_err;
    logic        wb_perr;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int checks   = 0;
    int failures = 0;

    // Per-transaction observations filled in by run_txn.
    int          r_ack_cnt, r_err_cnt, r_ack_cyc, r_err_cyc;
    int          r_bhs, r_rhs, r_awv, r_wv, r_arv, r_viol;
    logic [31:0] r_awaddr, r_wdata, r_araddr, r_dat;
    logic [3:0]  r_wstrb;
    logic [2:0]  r_prot;

    wb2axil_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .wb_adr_i        (wb_adr),
        .wb_dat_i        (wb_dat_w),
        .wb_sel_i        (wb_sel),
        .wb_we_i         (wb_we),
        .wb_cyc_i        (wb_cyc),
        .wb_stb_i        (wb_stb),
        .wb_dat_o        (wb_dat_r),
        .wb_ack_o        (wb_ack),
        .wb_err_o        (wb_err),
        .wb_posted_err_o (wb_perr),
        .m_axi_awaddr    (awaddr),
        .m_axi_awprot    (awprot),
        .m_axi_awvalid   (awvalid),
        .m_axi_awready   (awready),
        .m_axi_wdata     (wdata),
        .m_axi_wstrb     (wstrb),
        .m_axi_wvalid    (wvalid),
        .m_axi_wready    (wready),
        .m_axi_bresp     (bresp),
        .m_axi_bvalid    (bvalid),
        .m_axi_bready    (bready),
        .m_axi_araddr    (araddr),
        .m_axi_arprot    (arprot),
        .m_axi_arvalid   (arvalid),
        .m_axi_arready   (arready),
        .m_axi_rdata     (rdata),
        .m_axi_rresp     (rresp),
        .m_axi_rvalid    (rvalid),
        .m_axi_rready    (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One Wishbone cycle against a small AXI slave model with per-channel wait counts.
    task automatic run_txn(input logic t_we, input logic [31:0] t_adr, input logic [31:0] t_dat,
                           input logic [3:0] t_sel, input int aw_dly, input int w_dly,
                           input int ar_dly, input int rsp_dly, input logic [1:0] t_rsp,
                           input logic [31:0] t_rdata, input int drop_at);
        int aw_w = 0, w_w = 0, ar_w = 0, rs_w = 0;
        bit aw_d = 0, w_d = 0, ar_d = 0, rsp_d = 0, req_prev = 0;
        bit pav = 0, pwv = 0, parv = 0;
        logic [31:0] paw = '0, pw = '0, par = '0;
        r_ack_cnt = 0; r_err_cnt = 0; r_ack_cyc = -1; r_err_cyc = -1;
        r_bhs = 0; r_rhs = 0; r_awv = 0; r_wv = 0; r_arv = 0; r_viol = 0;
        r_awaddr = '0; r_wdata = '0; r_araddr = '0; r_dat = '0; r_wstrb = '0; r_prot = '0;
        wb_we = t_we; wb_adr = t_adr; wb_dat_w = t_dat; wb_sel = t_sel;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (pav && (!awvalid || awaddr !== paw)) r_viol++;
            if (pwv && (!wvalid || wdata !== pw))    r_viol++;
            if (parv && (!arvalid || araddr !== par)) r_viol++;
            if (awvalid) begin r_awv++; r_awaddr = awaddr; r_prot = r_prot | awprot; end
            if (wvalid)  begin r_wv++;  r_wdata = wdata; r_wstrb = wstrb; end
            if (arvalid) begin r_arv++; r_araddr = araddr; r_prot = r_prot | arprot; end
            if (wb_ack) begin r_ack_cnt++; if (r_ack_cyc < 0) r_ack_cyc = k; r_dat = wb_dat_r; end
            if (wb_err) begin r_err_cnt++; if (r_err_cyc < 0) r_err_cyc = k; r_dat = wb_dat_r; end
            if (wb_ack || wb_err || k == drop_at) begin
                wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
            end
            awready = awvalid && !aw_d && (aw_w >= aw_dly);
            if (awvalid && !aw_d) aw_w++;
            if (awvalid && awready) aw_d = 1;
            wready = wvalid && !w_d && (w_w >= w_dly);
            if (wvalid && !w_d) w_w++;
            if (wvalid && wready) w_d = 1;
            arready = arvalid && !ar_d && (ar_w >= ar_dly);
            if (arvalid && !ar_d) ar_w++;
            if (arvalid && arready) ar_d = 1;
            pav = awvalid && !awready; paw = awaddr;
            pwv = wvalid && !wready;   pw = wdata;
            parv = arvalid && !arready; par = araddr;
            bvalid = 1'b0; rvalid = 1'b0;
            if (req_prev && !rsp_d) begin
                if (t_we) begin
                    bvalid = (rs_w >= rsp_dly); bresp = t_rsp;
                    if (bvalid && bready) begin r_bhs++; rsp_d = 1; end
                end else begin
                    rvalid = (rs_w >= rsp_dly); rresp = t_rsp; rdata = t_rdata;
                    if (rvalid && rready) begin r_rhs++; rsp_d = 1; end
                end
                rs_w++;
            end
            req_prev = t_we ? (aw_d && w_d) : ar_d;
        end
        awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
        bresp = 2'b00; rresp = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, wb_ack, wb_err, wb_perr} !== 8'h00) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000000",
                     {awvalid, wvalid, bready, arvalid, rready, wb_ack, wb_err, wb_perr});
        end
        checks++;
        if (wb_dat_r !== 32'h0 || awaddr !== 32'h0 || wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got dat=%h awaddr=%h wdata=%h exp=0", wb_dat_r, awaddr, wdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({awvalid, wvalid, arvalid, wb_ack} !== 4'h0) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=0000", {awvalid, wvalid, arvalid, wb_ack});
        end
    endtask

    task automatic test_zero_wait_write();
        run_txn(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0, -1);
        checks++;
        if (r_awaddr !== 32'h0000_1004 || r_wdata !== 32'hDEAD_BEEF || r_wstrb !== 4'hF) begin
            failures++;
            $display("FAIL zw_payload got aw=%h w=%h s=%h exp aw=00001004 w=deadbeef s=f",
                     r_awaddr, r_wdata, r_wstrb);
        end
        checks++;
        if (r_ack_cyc !== (POSTED ? 2 : 3)) begin
            failures++; $display("FAIL zw_ack_cycle got=%0d exp=%0d", r_ack_cyc, POSTED ? 2 : 3);
        end
        checks++;
        if (r_ack_cnt !== 1 || r_err_cnt !== 0 || r_bhs !== 1) begin
            failures++;
            $display("FAIL zw_counts got ack=%0d err=%0d b=%0d exp 1 0 1", r_ack_cnt, r_err_cnt, r_bhs);
        end
        checks++;
        if (r_prot !== 3'b000) begin
            failures++; $display("FAIL zw_prot got=%b exp=000", r_prot);
        end
    endtask

    task automatic test_read_waits();
        run_txn(1'b0, 32'h0000_2003, 32'h0, 4'hF, 0, 0, 2, 3, 2'b00, 32'h1234_5678, -1);
        checks++;
        if (r_araddr !== 32'h0000_2000) begin
            failures++; $display("FAIL rw_araddr got=%h exp=00002000", r_araddr);
        end
        checks++;
        if (r_arv !== 3 || r_viol !== 0) begin
            failures++; $display("FAIL rw_arvalid_hold got cycles=%0d viol=%0d exp 3 0", r_arv, r_viol);
        end
        checks++;
        if (r_ack_cnt !== 1 || r_ack_cyc !== 8 || r_err_cnt !== 0) begin
            failures++;
            $display("FAIL rw_ack got cnt=%0d cyc=%0d err=%0d exp 1 8 0", r_ack_cnt, r_ack_cyc, r_err_cnt);
        end
        checks++;
        if (r_dat !== 32'h1234_5678) begin
            failures++; $display("FAIL rw_data got=%h exp=12345678", r_dat);
        end
    endtask

    task automatic test_skewed_write();
        run_txn(1'b1, 32'h0000_3010, 32'h0BAD_F00D, 4'h3, 4, 0, 0, 0, 2'b00, 32'h0, -1);
        checks++;
        if (r_wv !== 1 || r_awv !== 5 || r_viol !== 0) begin
            failures++;
            $display("FAIL sk_valids got w=%0d aw=%0d viol=%0d exp 1 5 0", r_wv, r_awv, r_viol);
        end
        checks++;
        if (r_bhs !== 1 || r_ack_cnt !== 1 || r_ack_cyc !== (POSTED ? 6 : 7)) begin
            failures++;
            $display("FAIL sk_resp got b=%0d ack=%0d cyc=%0d exp 1 1 %0d",
                     r_bhs, r_ack_cnt, r_ack_cyc, POSTED ? 6 : 7);
        end
        checks++;
        if (r_wstrb !== 4'h3 || r_awaddr !== 32'h0000_3010) begin
            failures++; $display("FAIL sk_payload got s=%h aw=%h exp 3 00003010", r_wstrb, r_awaddr);
        end
    endtask

    task automatic test_sel_zero();
        run_txn(1'b1, 32'h0000_100B, 32'hA5A5_A5A5, 4'h0, 0, 0, 0, 0, 2'b01, 32'h0, -1);
        checks++;
        if (r_wv !== 1 || r_wstrb !== 4'h0 || r_awaddr !== 32'h0000_1008) begin
            failures++;
            $display("FAIL sel0_write got w=%0d s=%h aw=%h exp 1 0 00001008", r_wv, r_wstrb, r_awaddr);
        end
        checks++;
        if (r_ack_cnt !== 1 || r_err_cnt !== 0) begin
            failures++; $display("FAIL sel0_exokay got ack=%0d err=%0d exp 1 0", r_ack_cnt, r_err_cnt);
        end
    endtask

    task automatic test_error();
        run_txn(1'b0, 32'h0000_5000, 32'h0, 4'hF, 0, 0, 0, 0, 2'b10, 32'hCAFE_F00D, -1);
        checks++;
        if (r_err_cnt !== 1 || r_err_cyc !== 3 || r_ack_cnt !== 0) begin
            failures++;
            $display("FAIL err_read got err=%0d cyc=%0d ack=%0d exp 1 3 0", r_err_cnt, r_err_cyc, r_ack_cnt);
        end
        checks++;
        if (r_dat !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL err_read_data got=%h exp=cafef00d", r_dat);
        end
        run_txn(1'b1, 32'h0000_5004, 32'h1357_9BDF, 4'hF, 0, 0, 0, 0, 2'b11, 32'h0, -1);
        checks++;
        if (r_err_cnt !== (POSTED ? 0 : 1) || r_ack_cnt !== (POSTED ? 1 : 0) || r_bhs !== 1) begin
            failures++;
            $display("FAIL err_write got err=%0d ack=%0d b=%0d exp %0d %0d 1",
                     r_err_cnt, r_ack_cnt, r_bhs, POSTED ? 0 : 1, POSTED ? 1 : 0);
        end
        checks++;
        if (wb_perr !== POSTED) begin
            failures++; $display("FAIL err_posted_flag got=%b exp=%b", wb_perr, POSTED);
        end
    endtask

    task automatic test_abandoned();
        run_txn(1'b0, 32'h0000_6000, 32'h0, 4'hF, 0, 0, 0, 1, 2'b00, 32'h0BAD_BEEF, 2);
        checks++;
        if (r_rhs !== 1 || r_ack_cnt !== 0 || r_err_cnt !== 0) begin
            failures++;
            $display("FAIL abandon got r=%0d ack=%0d err=%0d exp 1 0 0", r_rhs, r_ack_cnt, r_err_cnt);
        end
        checks++;
        if (wb_dat_r !== 32'h0BAD_BEEF) begin
            failures++; $display("FAIL abandon_data got=%h exp=0badbeef", wb_dat_r);
        end
        run_txn(1'b0, 32'h0000_6004, 32'h0, 4'hF, 0, 0, 0, 0, 2'b00, 32'h2468_ACE0, -1);
        checks++;
        if (r_ack_cnt !== 1 || r_ack_cyc !== 3 || r_dat !== 32'h2468_ACE0) begin
            failures++;
            $display("FAIL abandon_next got ack=%0d cyc=%0d dat=%h exp 1 3 2468ace0",
                     r_ack_cnt, r_ack_cyc, r_dat);
        end
    endtask

    task automatic test_reset_mid();
        wb_we = 1'b1; wb_adr = 32'h0000_7000; wb_dat_w = 32'h7777_0000; wb_sel = 4'hF;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        awready = 1'b0; wready = 1'b0;
        @(negedge clk);
        checks++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1) begin
            failures++; $display("FAIL rstmid_wrreq got aw=%b w=%b exp 1 1", awvalid, wvalid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, wb_ack, wb_err, wb_perr} !== 8'h00
            || wb_dat_r !== 32'h0 || awaddr !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_outputs got ctrl=%b dat=%h aw=%h exp 0",
                     {awvalid, wvalid, bready, arvalid, rready, wb_ack, wb_err, wb_perr}, wb_dat_r, awaddr);
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_txn(1'b0, 32'h0000_7004, 32'h0, 4'hF, 0, 0, 0, 0, 2'b00, 32'hFEED_0001, -1);
        checks++;
        if (r_ack_cnt !== 1 || r_ack_cyc !== 3 || r_dat !== 32'hFEED_0001) begin
            failures++;
            $display("FAIL rstmid_recover got ack=%0d cyc=%0d dat=%h exp 1 3 feed0001",
                     r_ack_cnt, r_ack_cyc, r_dat);
        end
    endtask

`ifdef WB2AXIL_POSTED_WRITE_EN
    task automatic test_posted_write();
        int n_ack = 0, n_err = 0, wr_ack = -1, rd_ack = -1, ar_first = -1;
        int perr_first = -1, perr_drop = 0, b_cyc = -1;
        bit b_done = 0;
        logic [31:0] rd_dat = '0;
        checks++;
        if (wb_perr !== 1'b0) begin
            failures++; $display("FAIL posted_start_flag got=%b exp=0", wb_perr);
        end
        wb_we = 1'b1; wb_adr = 32'h0000_4000; wb_dat_w = 32'h1111_2222; wb_sel = 4'hF;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (wb_err) n_err++;
            if (wb_ack) begin
                n_ack++;
                if (n_ack == 1) begin
                    wr_ack = k; wb_we = 1'b0; wb_adr = 32'h0000_3000;
                end else begin
                    rd_ack = k; rd_dat = wb_dat_r; wb_cyc = 1'b0; wb_stb = 1'b0;
                end
            end
            if (arvalid && ar_first < 0) ar_first = k;
            if (wb_perr && perr_first < 0) perr_first = k;
            if (perr_first >= 0 && !wb_perr) perr_drop++;
            bvalid = (k >= 7) && !b_done; bresp = 2'b10;
            if (bvalid && bready) begin b_done = 1; b_cyc = k; end
            rvalid = rready; rdata = 32'h55AA_55AA; rresp = 2'b00;
        end
        awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0; bresp = 2'b00;
        checks++;
        if (wr_ack !== 2 || b_cyc !== 7) begin
            failures++; $display("FAIL posted_ack_before_b got ack=%0d b=%0d exp 2 7", wr_ack, b_cyc);
        end
        checks++;
        if (ar_first !== 9) begin
            failures++; $display("FAIL posted_read_blocked got ar_first=%0d exp=9", ar_first);
        end
        checks++;
        if (perr_first !== 8 || perr_drop !== 0 || wb_perr !== 1'b1) begin
            failures++;
            $display("FAIL posted_err_sticky got first=%0d drops=%0d now=%b exp 8 0 1",
                     perr_first, perr_drop, wb_perr);
        end
        checks++;
        if (rd_ack !== 11 || rd_dat !== 32'h55AA_55AA || n_err !== 0) begin
            failures++;
            $display("FAIL posted_read got ack=%0d dat=%h err=%0d exp 11 55aa55aa 0", rd_ack, rd_dat, n_err);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        wb_adr = '0; wb_dat_w = '0; wb_sel = '0; wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bresp = 2'b00; bvalid = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;
        test_reset();
        test_zero_wait_write();
        test_read_waits();
        test_skewed_write();
        test_sel_zero();
        test_error();
        test_abandoned();
        test_reset_mid();
`ifdef WB2AXIL_POSTED_WRITE_EN
        test_posted_write();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
